// File: rtl/spart_host_ctrl.sv
// Host-side driver for a SPART: programs the baud divisor, then echoes received bytes through a small FIFO.
// Optional build macro SPART_HOST_UPCASE_EN folds ASCII lower-case letters to upper case on receive.
module spart_host_ctrl #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD0      = 4800,
    parameter int BAUD1      = 9600,
    parameter int BAUD2      = 19200,
    parameter int BAUD3      = 38400,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    input  logic                          rda,
    input  logic                          tbr,
    output logic                          iocs,
    output logic                          iorw,
    output logic [1:0]                    ioaddr,
    inout  wire  [7:0]                    databus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DIV0 = CLK_FREQ / (16 * BAUD0) - 1;
    localparam int DIV1 = CLK_FREQ / (16 * BAUD1) - 1;
    localparam int DIV2 = CLK_FREQ / (16 * BAUD2) - 1;
    localparam int DIV3 = CLK_FREQ / (16 * BAUD3) - 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        PROG_LO,
        PROG_HI,
        IDLE,
        READ,
        WRITE,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cfg_q, cfg_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];

    logic [DIV_W-1:0] div_sel;
    logic [15:0]      div16;
    logic [7:0]       rx_byte;
    logic [7:0]       dout;
    logic             fifo_full;
    logic             fifo_empty;

    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_cnt   = cnt_q;

    always_comb begin
        div_sel = DIV_W'(DIV0);
        case (cfg_q)
            2'd0:    div_sel = DIV_W'(DIV0);
            2'd1:    div_sel = DIV_W'(DIV1);
            2'd2:    div_sel = DIV_W'(DIV2);
            default: div_sel = DIV_W'(DIV3);
        endcase
        div16 = 16'(div_sel);
    end

    always_comb begin
        rx_byte = databus;
`ifdef SPART_HOST_UPCASE_EN
        if (databus >= 8'h61 && databus <= 8'h7A) begin
            rx_byte = databus - 8'h20;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cfg_d    = br_cfg;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        case (state_q)
            PROG_LO: state_d = PROG_HI;
            // A config change mid-programming restarts so the newest value wins.
            PROG_HI: state_d = (br_cfg != cfg_q) ? PROG_LO : GAP;
            IDLE: begin
                if (br_cfg != cfg_q) begin
                    state_d = PROG_LO;
                end else if (rda && !fifo_full) begin
                    state_d = READ;
                end else if (tbr && !fifo_empty) begin
                    state_d = WRITE;
                end
            end
            READ: begin
                mem_d[wr_ptr_q] = rx_byte;
                wr_ptr_d        = wr_ptr_q + 1'b1;
                cnt_d           = cnt_q + 1'b1;
                state_d         = GAP;
            end
            WRITE: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                cnt_d    = cnt_q - 1'b1;
                state_d  = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PROG_LO;
            cfg_q    <= br_cfg;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
        mem_q <= mem_d;
    end

    // Bus outputs decode the registered state; reset forces the idle bus immediately.
    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        dout   = 8'h00;
        busy   = 1'b0;
        if (rst) begin
            busy = 1'b1;
        end else begin
            case (state_q)
                PROG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b10;
                    dout   = div16[7:0];
                    busy   = 1'b1;
                end
                PROG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b11;
                    dout   = div16[15:8];
                    busy   = 1'b1;
                end
                READ: begin
                    iocs   = 1'b1;
                    iorw   = 1'b1;
                    ioaddr = 2'b00;
                end
                WRITE: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = 2'b00;
                    dout   = mem_q[rd_ptr_q];
                end
                default: begin
                    iocs   = 1'b0;
                    iorw   = 1'b1;
                    ioaddr = 2'b00;
                end
            endcase
        end
    end

    assign databus = (iocs && !iorw) ? dout : 8'hzz;

endmodule

// File: tb/tb_spart_host_ctrl.sv
// Bench for spart_host_ctrl: a behavioural SPART plus an echo-order model checked on every cycle.
// Honours SPART_HOST_UPCASE_EN the same way as the design build.
module tb_spart_host_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    wire        iocs;
    wire        iorw;
    wire  [1:0] ioaddr;
    wire  [7:0] databus;
    wire  [2:0] fifo_cnt;
    wire        busy;
    logic [7:0] tb_bus;

    always #5 clk = ~clk;

    // The SPART answers read cycles; otherwise the bus floats to the pull-ups (0xFF).
    assign databus = (iocs && iorw) ? tb_bus : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (databus[i]);
    end

    spart_host_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
        .fifo_cnt(fifo_cnt), .busy(busy)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_reads  = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] echo_q[$];
    logic       s_iocs, s_iorw, s_busy;
    logic [1:0] s_addr;
    logic [7:0] s_bus;
    logic [2:0] s_cnt;
    bit         rst_on_read = 0;

    typedef struct {
        logic [1:0] cfg;
        logic [7:0] lo;
        logic [7:0] hi;
    } prog_vec_t;
    prog_vec_t pv[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xform(input logic [7:0] b);
`ifdef SPART_HOST_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    task automatic drive();
        rda    = (rx_q.size() != 0);
        tb_bus = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic monitor(output bit rd_evt);
        rd_evt = 0;
        chk("fifo_cnt", s_cnt, exp_q.size());
        chk("busy", s_busy, s_iocs && !s_iorw && s_addr[1]);
        if (s_iocs && s_iorw) begin
            n_reads++;
            chk("read_addr", s_addr, 0);
            chk("read_not_full", exp_q.size() < DEPTH, 1);
            chk("read_has_byte", rx_q.size() != 0, 1);
            if (rx_q.size() != 0) begin
                exp_q.push_back(xform(rx_q[0]));
                rd_evt = 1;
            end
        end else if (s_iocs && s_addr == 2'b00) begin
            chk("write_not_empty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                chk("echo_byte", s_bus, exp_q[0]);
                void'(exp_q.pop_front());
            end
            echo_q.push_back(s_bus);
        end else if (!s_iocs) begin
            chk("idle_iorw", s_iorw, 1);
            chk("idle_addr", s_addr, 0);
            chk("idle_bus_z", s_bus, 8'hFF);
        end
    endtask

    task automatic step();
        bit rd_evt;
        rd_evt = 0;
        @(negedge clk);
        s_iocs = iocs; s_iorw = iorw; s_addr = ioaddr;
        s_bus  = databus; s_cnt = fifo_cnt; s_busy = busy;
        if (rst_on_read && s_iocs && s_iorw) begin
            rst         = 1'b1;
            rst_on_read = 0;
            exp_q.delete();
        end else if (!rst) begin
            monitor(rd_evt);
        end
        @(posedge clk);
        #1;
        if (rd_evt) void'(rx_q.pop_front());
        drive();
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        tbr  = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            done = (exp_q.size() == 0 && rx_q.size() == 0);
        end
        step();
        step();
        tbr = 1'b0;
        chk(name, done, 1);
    endtask

    task automatic check_prog(input string name, input logic [1:0] addr, input logic [7:0] val);
        chk({name, "_iocs"}, s_iocs, 1);
        chk({name, "_iorw"}, s_iorw, 0);
        chk({name, "_addr"}, s_addr, addr);
        chk({name, "_data"}, s_bus, val);
        chk({name, "_busy"}, s_busy, 1);
    endtask

    initial begin
        int e0;
        int r0;
        int n_rx;
        bit ok;
        logic [7:0] b;

        rst = 1'b1; br_cfg = 2'd0; tbr = 1'b0;
        drive();

        // Reset state.
        repeat (3) step();
        chk("rst_iocs", s_iocs, 0);
        chk("rst_iorw", s_iorw, 1);
        chk("rst_addr", s_addr, 0);
        chk("rst_busy", s_busy, 1);
        chk("rst_cnt", s_cnt, 0);
        chk("rst_bus_z", s_bus, 8'hFF);

        // Reset release with br_cfg=0: 0x8A, 0x02, GAP, IDLE.
        rst = 1'b0;
        step(); check_prog("rel_lo", 2'b10, 8'h8A);
        step(); check_prog("rel_hi", 2'b11, 8'h02);
        step(); chk("rel_gap_iocs", s_iocs, 0); chk("rel_gap_busy", s_busy, 0);
        step(); chk("rel_idle_iocs", s_iocs, 0);

        // Divisor programming for each baud select, changed while idle.
        pv[0] = '{2'd3, 8'h50, 8'h00};
        pv[1] = '{2'd1, 8'h44, 8'h01};
        pv[2] = '{2'd2, 8'hA1, 8'h00};
        pv[3] = '{2'd0, 8'h8A, 8'h02};
        pv[4] = '{2'd2, 8'hA1, 8'h00};
        pv[5] = '{2'd3, 8'h50, 8'h00};
        for (int i = 0; i < 6; i++) begin
            br_cfg = pv[i].cfg;
            step(); chk("tbl_idle_iocs", s_iocs, 0);
            step(); check_prog("tbl_lo", 2'b10, pv[i].lo);
            step(); check_prog("tbl_hi", 2'b11, pv[i].hi);
            step(); chk("tbl_gap_busy", s_busy, 0);
            step();
        end

        // Restart: 0 -> 3, then 2 arrives during PROG_HI.
        br_cfg = 2'd0;
        repeat (6) step();
        br_cfg = 2'd3;
        step();
        step(); check_prog("rs_lo3", 2'b10, 8'h50);
        br_cfg = 2'd2;
        step(); check_prog("rs_hi3", 2'b11, 8'h00);
        step(); check_prog("rs_lo2", 2'b10, 8'hA1);
        step(); check_prog("rs_hi2", 2'b11, 8'h00);
        step(); chk("rs_gap_iocs", s_iocs, 0); chk("rs_gap_busy", s_busy, 0);
        step();

        // Single byte 0x41 read then echoed.
        rx_q.push_back(8'h41);
        drive();
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = s_iocs && s_iorw;
        end
        chk("one_read_seen", ok, 1);
        chk("one_read_addr", s_addr, 0);
        step(); chk("one_cnt_after_read", s_cnt, 1);
        tbr = 1'b1;
        ok  = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = s_iocs && !s_iorw && s_addr == 2'b00;
        end
        tbr = 1'b0;
        chk("one_write_seen", ok, 1);
        chk("one_write_data", s_bus, 8'h41);
        step(); chk("one_cnt_after_write", s_cnt, 0);

        // Five bytes with tbr low: only four fit; the rest follows a write, across pointer wrap.
        r0 = n_reads;
        e0 = echo_q.size();
        for (int i = 0; i < 5; i++) rx_q.push_back(8'(8'h10 + 8'(i * 17)));
        drive();
        repeat (30) step();
        chk("full_reads", n_reads - r0, 4);
        chk("full_cnt", s_cnt, 4);
        chk("full_held", rx_q.size(), 1);
        drain("full_drain");
        chk("full_echo_count", echo_q.size() - e0, 5);

        // Case folding build option.
        rx_q.push_back(8'h62);
        rx_q.push_back(8'h5B);
        drive();
        drain("case_drain");
`ifdef SPART_HOST_UPCASE_EN
        chk("case_62", echo_q[echo_q.size()-2], 8'h42);
`else
        chk("case_62", echo_q[echo_q.size()-2], 8'h62);
`endif
        chk("case_5b", echo_q[echo_q.size()-1], 8'h5B);

        // Reset during a READ with two bytes queued.
        rx_q.push_back(8'h21);
        rx_q.push_back(8'h22);
        drive();
        repeat (12) step();
        chk("mid_cnt2", s_cnt, 2);
        rx_q.push_back(8'h33);
        drive();
        rst_on_read = 1;
        for (int i = 0; i < 10 && !rst; i++) step();
        chk("mid_rst_hit", rst, 1);
        rst_on_read = 0;
        step();
        chk("mid_rst_iocs", s_iocs, 0);
        chk("mid_rst_cnt", s_cnt, 0);
        chk("mid_rst_busy", s_busy, 1);
        rst = 1'b0;
        step();
        chk("mid_rel_iocs", s_iocs, 1);
        chk("mid_rel_addr", s_addr, 2'b10);
        e0 = echo_q.size();
        drain("mid_drain");
        chk("mid_echo_count", echo_q.size() - e0, 1);
        chk("mid_echo_byte", echo_q[echo_q.size()-1], 8'h33);

        // Randomized traffic against the echo model.
        e0   = echo_q.size();
        n_rx = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0 && rx_q.size() < 3) begin
                b = 8'($urandom_range(0, 255));
                rx_q.push_back(b);
                n_rx++;
            end
            tbr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) br_cfg = 2'($urandom_range(0, 3));
            drive();
            step();
        end
        drain("rand_drain");
        chk("rand_echo_count", echo_q.size() - e0, n_rx);
        chk("rand_final_cnt", s_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
